// File: rtl/camo_gate_bank_seq.sv
// Bank of key-selectable 2-input cells (NAND/NOR/XOR) with a serially loaded,
// commit-once key and registered outputs carrying a valid strobe.
module camo_gate_bank_seq #(
  parameter  int N_GATES = 6,
  localparam int KEY_W   = 2 * N_GATES,
  localparam int CNT_W   = $clog2(KEY_W + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_sen,
  input  logic               key_sin,
  input  logic               key_commit,
  output logic               key_locked,
  output logic               key_err,
  input  logic               in_valid,
  input  logic [N_GATES-1:0] in_a,
  input  logic [N_GATES-1:0] in_b,
  output logic               out_valid,
  output logic [N_GATES-1:0] out_y
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LOCKED = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(KEY_W + 1);

  state_t             state, state_nxt;
  logic [KEY_W-1:0]   shadow;
  logic [KEY_W-1:0]   active_key;
  logic [CNT_W-1:0]   cnt;
  logic [N_GATES-1:0] cell_y;

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (key_commit) state_nxt = (cnt == CNT_FULL) ? LOCKED : ERR;
      ERR:     if (key_sen) state_nxt = LOAD;
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Commit takes priority over a same-cycle shift, so it sees the pre-shift shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      active_key <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (key_commit) begin
            if (cnt == CNT_FULL) begin
              active_key <= shadow;
            end else begin
              shadow <= '0;
              cnt    <= '0;
            end
          end else if (key_sen) begin
            shadow <= {key_sin, shadow[KEY_W-1:1]};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          if (key_sen) begin
            shadow <= {key_sin, shadow[KEY_W-1:1]};
            cnt    <= CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cell_y = '0;
    for (int unsigned i = 0; i < N_GATES; i++) begin
      if (active_key[2*i])        cell_y[i] = in_a[i] ^ in_b[i];
      else if (active_key[2*i+1]) cell_y[i] = ~(in_a[i] | in_b[i]);
      else                        cell_y[i] = ~(in_a[i] & in_b[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else begin
      out_valid <= in_valid && (state == LOCKED);
      if (in_valid && (state == LOCKED)) out_y <= cell_y;
    end
  end

  assign key_locked = (state == LOCKED);
  assign key_err    = (state == ERR);

endmodule

// File: tb/tb_camo_gate_bank_seq.sv
// Scoreboard bench for camo_gate_bank_seq: expected outputs are queued when
// operands are driven and compared when out_valid appears.
module tb_camo_gate_bank_seq;

  localparam int N = 6;
  localparam int KW = 2 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_sen, key_sin, key_commit;
  logic         key_locked, key_err;
  logic         in_valid;
  logic [N-1:0] in_a, in_b;
  logic         out_valid;
  logic [N-1:0] out_y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] sb_q[$];

  camo_gate_bank_seq #(.N_GATES(N)) dut (
    .clk(clk), .rst(rst),
    .key_sen(key_sen), .key_sin(key_sin), .key_commit(key_commit),
    .key_locked(key_locked), .key_err(key_err),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_y(out_y)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model(input logic [KW-1:0] k,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [N-1:0] y;
    y = '0;
    for (int i = 0; i < N; i++) begin
      case ({k[2*i+1], k[2*i]})
        2'b00:   y[i] = ~(a[i] & b[i]);
        2'b10:   y[i] = ~(a[i] | b[i]);
        default: y[i] = a[i] ^ b[i];
      endcase
    end
    return y;
  endfunction

  // Output monitor: every valid result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: out_y=%b, no result expected", out_y);
      end else begin
        logic [N-1:0] exp_y;
        exp_y = sb_q.pop_front();
        if (out_y !== exp_y) begin
          n_fail++;
          $display("FAIL out_y: got %b expected %b", out_y, exp_y);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key_sen = 1'b0; key_sin = 1'b0; key_commit = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic shift_key(input logic [KW-1:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_sen = 1'b1;
      key_sin = k[i % KW];
      tick();
    end
    key_sen = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    tick();
    key_commit = 1'b0;
  endtask

  task automatic check_key_flags(input string name, input logic exp_lock, input logic exp_err);
    n_checks++;
    if (key_locked !== exp_lock || key_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s: key_locked=%b key_err=%b expected key_locked=%b key_err=%b",
               name, key_locked, key_err, exp_lock, exp_err);
    end
  endtask

  // Operand expected to be dropped: no strobe and out_y must hold exp_hold.
  task automatic send_dropped(input string name, input logic [N-1:0] a,
                              input logic [N-1:0] b, input logic [N-1:0] exp_hold);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== exp_hold) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out_y=%b expected out_valid=0 out_y=%b",
               name, out_valid, out_y, exp_hold);
    end
  endtask

  task automatic send(input logic [KW-1:0] k, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    sb_q.push_back(model(k, a, b));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lock_key(input logic [KW-1:0] k);
    shift_key(k, KW);
    commit();
  endtask

  task automatic test_reset();
    do_reset();
    check_key_flags("reset_flags", 1'b0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== '0) begin
      n_fail++;
      $display("FAIL reset_out: out_valid=%b out_y=%b expected 0/0", out_valid, out_y);
    end
  endtask

  task automatic test_basic();
    do_reset();
    shift_key(12'h018, KW);
    check_key_flags("basic_before_commit", 1'b0, 1'b0);
    send_dropped("basic_commit_cycle_drop", 6'b000101, 6'b000110, 6'b000000);
    commit();
    check_key_flags("basic_locked", 1'b1, 1'b0);
    n_checks++;
    if (model(12'h018, 6'b000101, 6'b000110) !== 6'b111001 || out_y !== 6'b000000) begin
      n_fail++;
      $display("FAIL basic_preop: out_y=%b expected 000000 before first result", out_y);
    end
    send(12'h018, 6'b000101, 6'b000110);
    tick();
  endtask

  task automatic test_short_key();
    do_reset();
    shift_key(12'h018, KW - 1);
    commit();
    check_key_flags("short_err", 1'b0, 1'b1);
    send_dropped("short_drop0", 6'b000101, 6'b000110, 6'b000000);
    send_dropped("short_drop1", 6'b111111, 6'b000000, 6'b000000);
    commit();
    check_key_flags("err_commit_ignored", 1'b0, 1'b1);
  endtask

  task automatic test_recover();
    // Continues from ERR left by test_short_key.
    shift_key(12'hFFF, 1);
    check_key_flags("recover_first_shift", 1'b0, 1'b0);
    shift_key(12'hFFF >> 1, KW - 1);
    commit();
    check_key_flags("recover_locked", 1'b1, 1'b0);
    send(12'hFFF, 6'h2A, 6'h0F);
    tick();
  endtask

  task automatic test_overshift();
    do_reset();
    shift_key(12'h018, KW + 1);
    commit();
    check_key_flags("overshift_err", 1'b0, 1'b1);
  endtask

  task automatic test_locked_ignore();
    do_reset();
    lock_key(12'h018);
    shift_key(12'h000, KW);
    commit();
    check_key_flags("locked_ignore_flags", 1'b1, 1'b0);
    send(12'h018, 6'b000101, 6'b000110);
    tick();
  endtask

  task automatic test_commit_with_shift();
    do_reset();
    shift_key(12'h018, KW - 1);
    key_sen = 1'b1; key_sin = 1'b0; key_commit = 1'b1;
    tick();
    key_sen = 1'b0; key_commit = 1'b0;
    check_key_flags("commit_with_shift", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [KW-1:0] k;
    do_reset();
    k = KW'($urandom);
    lock_key(k);
    check_key_flags("b2b_locked", 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom); b = N'($urandom);
      in_valid = 1'b1; in_a = a; in_b = b;
      sb_q.push_back(model(k, a, b));
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_locked();
    do_reset();
    lock_key(12'h018);
    in_valid = 1'b1; in_a = 6'b000101; in_b = 6'b000110; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || key_locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_locked: out_valid=%b out_y=%b key_locked=%b expected 0/000000/0",
               out_valid, out_y, key_locked);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_key();
    test_recover();
    test_overshift();
    test_locked_ignore();
    test_commit_with_shift();
    test_back_to_back();
    test_reset_locked();
    tick(); tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
